pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline-stage register replacing the per-stage hand-written registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle, a data bundle and debug PC between stages.
- Adds valid/ready handshake, stall back-pressure, synchronous flush with control zeroing, and a saturating stall-cycle counter.
- Optional skid buffer registers in_ready to break the combinational ready path.

Parameters:
CTRL_W, 8, width of control bundle (write enables, wd_sel, etc.); zeroed on bubble and flush
DATA_W, 101, width of data bundle (wR, wD, ALU result, rd2, ...)
PC_W, 32, width of debug PC
CNT_W, 16, width of stall-cycle counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  squash stage contents (branch or exception redirect)
in_valid  in  1  upstream presents an instruction
in_ready  out  1  stage accepts this cycle
in_ctrl  in  CTRL_W  control bundle
in_data  in  DATA_W  data bundle
in_pc  in  PC_W  debug PC
out_valid  out  1  stage holds an instruction (debug_have_inst equivalent)
out_ready  in  1  downstream accepts
out_ctrl  out  CTRL_W  registered control; all-zero whenever out_valid=0
out_data  out  DATA_W  registered data; holds last value when out_valid=0
out_pc  out  PC_W  registered debug PC
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Latency in→out is 1 cycle.
- Reset (rst=1 at a posedge): out_valid=0, out_ctrl=0, out_data=0, out_pc=0, stall_cnt=0, state=EMPTY, skid slot cleared.
- in_ready is 0 whenever rst=1.
- Reset mid-transfer discards all held entries with no output fire.
- Build without skid (states EMPTY, FULL):
  - in_ready = ~rst & (~out_valid | out_ready), combinational.
  - On in_fire: main register loads in_* and state=FULL.
  - On out_fire without in_fire: state=EMPTY and out_ctrl forced to 0.
  - Simultaneous in_fire and out_fire: main register reloads, state stays FULL.
- Flush:
  - Next state is EMPTY; out_valid=0 and out_ctrl=0 on the following cycle.
  - Skid slot dropped.
  - Flush beats a simultaneous in_fire: the incoming entry is discarded, upstream still sees in_ready as computed.
- Bubble rule: out_ctrl is forced to all-zero whenever out_valid=0. Consumers that ignore out_valid therefore never see a stray write enable.
- Data during bubble: out_data and out_pc hold their last value.
- Stall counter:
  - Increments by 1 every cycle with out_valid & ~out_ready.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Unaffected by flush; cleared only by rst.
- Stall: out_ready=0 with out_valid=1 holds out_* stable, byte-for-byte, until out_fire or flush.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- When defined:
  - Adds a one-entry skid slot and state SKID.
  - in_ready becomes a register: 1 in EMPTY and FULL, 0 in SKID and during rst.
- Transitions with the macro defined:
  - EMPTY + in_fire → FULL.
  - FULL + in_fire & ~out_fire → SKID; the new entry goes into the skid slot.
  - FULL + ~in_fire & out_fire → EMPTY.
  - FULL + both fires → FULL, main reloaded.
  - SKID + out_fire → FULL; the skid slot moves to main.
  - SKID + ~out_fire → SKID.
  - flush from any state → EMPTY.
- Ordering is strict FIFO; no entry is ever lost or duplicated.
- When undefined: two-state behaviour above; combinational in_ready; no skid storage.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding localparams: ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2;
  - default widths for each stage's CTRL_W and DATA_W, so the EX/MEM and MEM/WB instantiations agree.
- Single module; no sub-module. The skid slot is a plain register bank inside the `ifdef`.

Test Plan:
- Reset and first transfer: hold rst 3 cycles, then drive in_valid=1, in_ctrl=8'hA5, in_pc=32'h0000_1000, out_ready=1. Required: in_ready=0 during reset; next cycle out_valid=1, out_ctrl=8'hA5, out_pc=32'h1000.
- Stall: out_ready=0 for 5 cycles with a held entry (in_pc=32'h2000). Required: out_* unchanged, stall_cnt=5. With skid enabled, exactly one extra entry (pc 32'h2004) accepted, then in_ready=0.
- Stall release order: release out_ready. Required: pc 32'h2000 then 32'h2004 emerge on consecutive cycles, no loss or duplicate.
- Flush with capture: flush=1 with in_valid=1, in_ctrl=8'hFF. Required: next cycle out_valid=0, out_ctrl=0, skid empty, stall_cnt unchanged.
- Back-to-back streaming: 16 back-to-back transfers with out_ready=1, pc 32'h0,4,...,3C. Required: throughput 1/cycle, outputs in order, out_ctrl=0 on every idle cycle.
- Counter saturation: with CNT_W=4, stall for 20 cycles. Required: stall_cnt saturates at 4'hF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for pipe_stage_reg: state encoding and the per-stage
// bundle widths that every pipeline-stage instantiation agrees on.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  // Default bundle widths per pipeline boundary.
  localparam int IFID_CTRL_W  = 8;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 8;
  localparam int IDEX_DATA_W  = 101;
  localparam int EXMEM_CTRL_W = 8;
  localparam int EXMEM_DATA_W = 101;
  localparam int MEMWB_CTRL_W = 8;
  localparam int MEMWB_DATA_W = 101;

  localparam int STAGE_PC_W  = 32;
  localparam int STAGE_CNT_W = 16;

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready handshake, flush, control
// zeroing on bubbles and a saturating stall counter. Define PIPE_STAGE_SKID_EN
// to add a one-entry skid slot and a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int PC_W   = STAGE_PC_W,
  parameter int CNT_W  = STAGE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [PC_W-1:0]   pc_q,    pc_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic in_fire;
  logic out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [PC_W-1:0]   skid_pc_q,   skid_pc_d;
  logic              in_ready_q,  in_ready_d;

  // Ready comes straight from a flop; rst gating keeps it low while reset is held.
  assign in_ready = in_ready_q & ~rst;
`else
  assign in_ready = ~rst & (~out_valid | out_ready);
`endif

  // ctrl_q is cleared every time the stage empties, so out_ctrl is
  // zero during bubbles without any output masking.
  assign out_ctrl  = ctrl_q;
  assign out_data  = data_q;
  assign out_pc    = pc_q;
  assign stall_cnt = cnt_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    pc_d    = pc_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
`endif

    if (flush) begin
      // Flush wins over any capture; data and pc keep their last value.
      state_d = ST_EMPTY;
      ctrl_d  = '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_ctrl_d = '0;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_FULL;
            ctrl_d  = in_ctrl;
            data_d  = in_data;
            pc_d    = in_pc;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            ctrl_d = in_ctrl;
            data_d = in_data;
            pc_d   = in_pc;
`ifdef PIPE_STAGE_SKID_EN
          end else if (in_fire) begin
            state_d     = ST_SKID;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            skid_pc_d   = in_pc;
`endif
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            ctrl_d  = '0;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_SKID: begin
          if (out_fire) begin
            state_d     = ST_FULL;
            ctrl_d      = skid_ctrl_q;
            data_d      = skid_data_q;
            pc_d        = skid_pc_q;
            skid_ctrl_d = '0;
          end
        end
`endif
        default: begin
          state_d = ST_EMPTY;
          ctrl_d  = '0;
        end
      endcase
    end

`ifdef PIPE_STAGE_SKID_EN
    in_ready_d = (state_d != ST_SKID);
`endif
  end

  // Stall counter ignores flush and saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ctrl_q  <= '0;
      // NOTE: the datapath registers are reset too, because out_data/out_pc must read zero after reset.
      data_q  <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_pc_q   <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
      in_ready_q  <= in_ready_d;
    end
  end
`endif

endmodule : pipe_stage_reg
